// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt sequencer: instruction encodings,
// CSR addresses, trap causes, FSM states and mstatus rewrite helpers.
package clint_pkg;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
`ifdef CLINT_EBREAK_EN
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
`endif

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL = 32'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_ASSERT,
    S_W_MRET,
    S_ASSERT_RET
  } clint_state_e;

  // Trap entry: MPIE takes the old MIE, MIE is cleared.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // Trap return: MIE restored from MPIE, MPIE set.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r               = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer: stalls the pipe, writes mepc/mcause/mstatus,
// then redirects the PC. Define CLINT_EBREAK_EN to make ebreak trap with cause 3.
module clint
  import clint_pkg::*;
#(
  parameter logic [31:0] ASYNC_CAUSE = 32'h8000_0007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  clint_state_e state_q, state_d;
  logic [31:0]  epc_q, epc_d;
  logic [31:0]  cause_q, cause_d;
  logic [31:0]  mstatus_q, mstatus_d;

  logic        is_ecall, is_ebreak, is_mret;
  logic        sync_req, async_req, detect_en;
  logic [31:0] sync_cause;

  assign is_ecall = (inst_i == INST_ECALL);
  assign is_mret  = (inst_i == INST_MRET);
`ifdef CLINT_EBREAK_EN
  assign is_ebreak  = (inst_i == INST_EBREAK);
  assign sync_cause = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
`else
  assign is_ebreak  = 1'b0;
  assign sync_cause = CAUSE_ECALL;
`endif
  assign sync_req  = is_ecall | is_ebreak;
  assign async_req = (int_flag_i != 8'h00) & global_int_en_i &
                     csr_mstatus_i[MSTATUS_MIE] & ~hold_flag_i;
  // Detection is suppressed while rst is held so every output reads 0 during reset.
  assign detect_en = (state_q == S_IDLE) & ~rst;

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    mstatus_d = mstatus_q;
    case (state_q)
      S_IDLE: begin
        if (detect_en) begin
          if (sync_req) begin
            state_d   = S_W_MEPC;
            epc_d     = inst_addr_i;
            cause_d   = sync_cause;
            mstatus_d = csr_mstatus_i;
          end else if (is_mret) begin
            state_d   = S_W_MRET;
            mstatus_d = csr_mstatus_i;
          end else if (async_req) begin
            state_d   = S_W_MEPC;
            epc_d     = jump_flag_i ? jump_addr_i : inst_addr_i;
            cause_d   = ASYNC_CAUSE;
            mstatus_d = csr_mstatus_i;
          end
        end
      end
      S_W_MEPC:     state_d = S_W_MCAUSE;
      S_W_MCAUSE:   state_d = S_W_MSTATUS;
      S_W_MSTATUS:  state_d = S_ASSERT;
      S_ASSERT:     state_d = S_IDLE;
      S_W_MRET:     state_d = S_ASSERT_RET;
      S_ASSERT_RET: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      epc_q     <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      mstatus_q <= mstatus_d;
    end
  end

  always_comb begin
    hold_flag_o  = 1'b0;
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state_q)
      S_IDLE: hold_flag_o = detect_en & (sync_req | is_mret | async_req);
      S_W_MEPC: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = CSR_MEPC;
        data_o      = epc_q;
      end
      S_W_MCAUSE: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = CSR_MCAUSE;
        data_o      = cause_q;
      end
      S_W_MSTATUS: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = CSR_MSTATUS;
        data_o      = trap_mstatus(mstatus_q);
      end
      S_ASSERT: begin
        hold_flag_o  = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = csr_mtvec_i;
      end
      S_W_MRET: begin
        hold_flag_o = 1'b1;
        we_o        = 1'b1;
        waddr_o     = CSR_MSTATUS;
        data_o      = mret_mstatus(mstatus_q);
      end
      S_ASSERT_RET: begin
        hold_flag_o  = 1'b1;
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint.sv
// Randomized bench for clint against a cycle-schedule reference model with a small CSR file.
module tb_clint;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef CLINT_EBREAK_EN
  localparam bit EBREAK_ON = 1'b1;
`else
  localparam bit EBREAK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, hold_flag_i, global_int_en_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;

  clint dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .global_int_en_i(global_int_en_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One expected output cycle; the redirect target is resolved from the CSR file at that cycle.
  typedef struct packed {
    logic        hold;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] data;
    logic        asrt;
    logic        from_mepc;
  } exp_t;

  exp_t        sched[$];
  logic [31:0] m_mstatus, m_mepc, m_mtvec, m_mcause;

  function automatic exp_t mk(input logic hold, input logic we, input logic [31:0] waddr,
                              input logic [31:0] data, input logic asrt, input logic from_mepc);
    exp_t e;
    e.hold = hold; e.we = we; e.waddr = waddr; e.data = data;
    e.asrt = asrt; e.from_mepc = from_mepc;
    return e;
  endfunction

  task automatic plan_trap(input logic [31:0] epc, input logic [31:0] cause, input logic [31:0] ms);
    logic [31:0] nms;
    nms    = ms;
    nms[7] = ms[3];
    nms[3] = 1'b0;
    sched.push_back(mk(1'b1, 1'b1, 32'h341, epc, 1'b0, 1'b0));
    sched.push_back(mk(1'b1, 1'b1, 32'h342, cause, 1'b0, 1'b0));
    sched.push_back(mk(1'b1, 1'b1, 32'h300, nms, 1'b0, 1'b0));
    sched.push_back(mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0));
  endtask

  task automatic plan_mret(input logic [31:0] ms);
    logic [31:0] nms;
    nms    = ms;
    nms[3] = ms[7];
    nms[7] = 1'b1;
    sched.push_back(mk(1'b1, 1'b1, 32'h300, nms, 1'b0, 1'b0));
    sched.push_back(mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1));
  endtask

  // Called at a falling edge with inputs already set; checks, then advances one clock.
  task automatic step(input string tag);
    exp_t        e;
    logic [31:0] eaddr;
    logic        is_sync, is_async;
    csr_mstatus_i = m_mstatus;
    csr_mepc_i    = m_mepc;
    csr_mtvec_i   = m_mtvec;
    #1;
    e = '0;
    if (rst) begin
      sched.delete();
    end else if (sched.size() > 0) begin
      e = sched.pop_front();
    end else begin
      is_sync  = (inst_i == ECALL) || (EBREAK_ON && inst_i == EBREAK);
      is_async = (int_flag_i != 8'h00) && global_int_en_i && csr_mstatus_i[3] && !hold_flag_i;
      if (is_sync) begin
        e.hold = 1'b1;
        plan_trap(inst_addr_i, (inst_i == ECALL) ? 32'd11 : 32'd3, csr_mstatus_i);
      end else if (inst_i == MRET) begin
        e.hold = 1'b1;
        plan_mret(csr_mstatus_i);
      end else if (is_async) begin
        e.hold = 1'b1;
        plan_trap(jump_flag_i ? jump_addr_i : inst_addr_i, 32'h8000_0007, csr_mstatus_i);
      end
    end
    eaddr = e.asrt ? (e.from_mepc ? m_mepc : m_mtvec) : 32'h0;
    check_eq({tag, ".hold"},   {31'b0, hold_flag_o},  {31'b0, e.hold});
    check_eq({tag, ".we"},     {31'b0, we_o},         {31'b0, e.we});
    check_eq({tag, ".waddr"},  waddr_o,               e.waddr);
    check_eq({tag, ".data"},   data_o,                e.data);
    check_eq({tag, ".assert"}, {31'b0, int_assert_o}, {31'b0, e.asrt});
    check_eq({tag, ".addr"},   int_addr_o,            eaddr);
    @(posedge clk);
    if (e.we) begin
      case (e.waddr)
        32'h300: m_mstatus = e.data;
        32'h341: m_mepc    = e.data;
        32'h342: m_mcause  = e.data;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    inst_i          = NOP;
    inst_addr_i     = 32'h0;
    int_flag_i      = 8'h00;
    jump_flag_i     = 1'b0;
    jump_addr_i     = 32'h0;
    hold_flag_i     = 1'b0;
    global_int_en_i = 1'b1;
  endtask

  task automatic run_idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    logic [3:0] r;
    rst = 1'b1;
    quiet_inputs();
    m_mstatus = 32'h0; m_mepc = 32'h0; m_mtvec = 32'h80; m_mcause = 32'h0;
    @(negedge clk);
    run_idle("reset", 2);
    rst = 1'b0;
    run_idle("idle", 2);

    // ecall at 0x100, mtvec 0x80, MIE=1
    m_mstatus = 32'h8; m_mtvec = 32'h80;
    inst_i = ECALL; inst_addr_i = 32'h100;
    step("ecall.T");
    inst_i = NOP;
    run_idle("ecall.seq", 5);

    // mret with mepc 0x104, mstatus 0x80
    m_mepc = 32'h104; m_mstatus = 32'h80;
    inst_i = MRET; step("mret.T");
    inst_i = NOP;
    run_idle("mret.seq", 3);

    // async with jump redirect, then held with MIE now 0
    m_mstatus = 32'h8;
    int_flag_i = 8'h01; jump_flag_i = 1'b1; jump_addr_i = 32'h200; inst_addr_i = 32'h300;
    run_idle("async", 8);
    int_flag_i = 8'h00; jump_flag_i = 1'b0;
    m_mstatus = 32'h0; int_flag_i = 8'h01;
    run_idle("async.mie0", 3);
    m_mstatus = 32'h8; global_int_en_i = 1'b0;
    run_idle("async.gie0", 3);
    quiet_inputs();

    // ecall and interrupt together, interrupt held across return and mret
    m_mstatus = 32'h8; inst_i = ECALL; inst_addr_i = 32'h400; int_flag_i = 8'h04;
    step("both.T");
    inst_i = NOP;
    run_idle("both.seq", 7);
    inst_i = MRET; step("both.mret");
    inst_i = NOP;
    run_idle("both.retake", 7);
    quiet_inputs();
    run_idle("both.tail", 2);

    // reset during the mcause write
    m_mstatus = 32'h8; inst_i = ECALL; inst_addr_i = 32'h500;
    step("rst.T");
    inst_i = NOP;
    step("rst.mepc");
    rst = 1'b1;
    step("rst.mcause");
    rst = 1'b0;
    run_idle("rst.after", 4);

    // ebreak at 0x40
    m_mstatus = 32'h8; inst_i = EBREAK; inst_addr_i = 32'h40;
    step("ebreak.T");
    inst_i = NOP;
    run_idle("ebreak.seq", 5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      r = 4'($urandom_range(0, 9));
      case (r)
        4'd0:    inst_i = ECALL;
        4'd1:    inst_i = EBREAK;
        4'd2:    inst_i = MRET;
        default: inst_i = $urandom;
      endcase
      inst_addr_i     = $urandom & 32'hFFFF_FFFC;
      int_flag_i      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      jump_flag_i     = 1'($urandom);
      jump_addr_i     = $urandom & 32'hFFFF_FFFC;
      hold_flag_i     = ($urandom_range(0, 3) == 0);
      global_int_en_i = ($urandom_range(0, 3) != 0);
      m_mtvec         = $urandom & 32'hFFFF_FFFC;
      if (sched.size() == 0 && $urandom_range(0, 9) == 0) m_mstatus = $urandom;
      step("rand");
    end
    rst = 1'b0;
    quiet_inputs();
    run_idle("drain", 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
